// File: rtl/memory_unit_pkg.sv
// memory_unit_pkg
//   Shared definitions for the memory_unit slice: default geometry and the
//   two-state controller encoding (LOAD = 0, RUN = 1).
package memory_unit_pkg;

  localparam int ADDR_W_DEFAULT = 5;   // 32 words
  localparam int DATA_W_DEFAULT = 16;  // must be even: a word is two preload halves

  typedef enum logic {
    LOAD = 1'b0,  // byte-wise preload in progress, processor locked out
    RUN  = 1'b1   // serving processor accesses
  } state_t;

endpackage : memory_unit_pkg

// File: rtl/memory_unit_mem_array.sv
// memory_unit_mem_array
//   Word storage with one synchronous write port and one registered read
//   port. When the write and read addresses match on an enabled read, the
//   read register takes the write data (write-first).
//   Ports:
//     clk    : clock, rising edge
//     rst    : async active-high reset, clears only the read register
//     we     : write enable
//     waddr  : write address
//     wdata  : write data
//     rd_en  : read register update enable (holds its value when low)
//     raddr  : read address
//     rdata  : registered read data
module memory_unit_mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is intentionally left without reset so contents survive rst.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (rd_en) begin
      // Bypass so the output reflects the word as it stands after this edge.
      if (we && (waddr == raddr)) begin
        rdata_reg <= wdata;
      end else begin
        rdata_reg <= mem[raddr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule : memory_unit_mem_array

// File: rtl/memory_unit.sv
// memory_unit
//   Word memory that is first filled by a byte-serial preload stream (word 0
//   first, low byte then high byte), then serves single-cycle processor
//   reads/writes. A preload may be cut short with skip_load.
//   Ports:
//     clk        : clock, rising edge
//     rst        : async active-high reset -> LOAD, preload restarts at word 0
//     address    : processor word address
//     data_in    : processor write data
//     readwriteN : 1 = write, 0 = read (RUN only)
//     data_out   : registered read data, 1-cycle latency, write-first
//     load_valid : preload byte valid
//     load_byte  : preload byte
//     load_ready : preload byte accepted when load_valid && load_ready
//     skip_load  : abandon preload and go to RUN
//     busy       : high while not in RUN
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              readwriteN,
  output logic [DATA_W-1:0] data_out,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              skip_load,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] load_addr_reg, load_addr_next;
  logic              phase_reg, phase_next;   // 0 = expecting low byte
  logic [7:0]        byte_reg, byte_next;     // holds the low byte of a word
  logic              load_we;
  logic              run;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] load_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= LOAD;
      load_addr_reg <= '0;
      phase_reg     <= 1'b0;
      byte_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      load_addr_reg <= load_addr_next;
      phase_reg     <= phase_next;
      byte_reg      <= byte_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_addr_next = load_addr_reg;
    phase_next     = phase_reg;
    byte_next      = byte_reg;
    load_we        = 1'b0;
    load_ready     = 1'b0;
    busy           = 1'b0;
    case (state_reg)
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          if (phase_reg) begin
            // High byte completes the word; the counter wraps naturally.
            load_we        = 1'b1;
            load_addr_next = load_addr_reg + ADDR_W'(1);
            phase_next     = 1'b0;
            if (load_addr_reg == LAST_ADDR) begin
              state_next = RUN;
            end
          end else begin
            byte_next  = load_byte;
            phase_next = 1'b1;
          end
        end
        // A completing word on this edge is still written (load_we above);
        // a pending low byte is simply dropped.
        if (skip_load) begin
          state_next = RUN;
          phase_next = 1'b0;
        end
      end
      RUN: begin
        busy = 1'b0;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  assign run       = (state_reg == RUN);
  assign load_word = {HALF_W'(load_byte), HALF_W'(byte_reg)};

  // Single write port shared between preload and processor.
  assign mem_we    = run ? readwriteN : load_we;
  assign mem_waddr = run ? address    : load_addr_reg;
  assign mem_wdata = run ? data_in    : load_word;

  memory_unit_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .rd_en (run),
    .raddr (address),
    .rdata (data_out)
  );

endmodule : memory_unit

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter ADDR_W, default 5, word address width (depth 2**ADDR_W = 32 words).
REQ-002 Parameter DATA_W, default 16, word width; must be an even number.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 address  input  ADDR_W  processor access address.
REQ-006 data_in  input  DATA_W  processor write data (driven by processor data_out).
REQ-007 readwriteN  input  1  1 = write, 0 = read.
REQ-008 data_out  output  DATA_W  registered read data (feeds processor data_in).
REQ-009 load_valid  input  1  preload byte valid.
REQ-010 load_byte  input  8  preload byte.
REQ-011 load_ready  output  1  preload byte accepted when load_valid && load_ready.
REQ-012 skip_load  input  1  abandon preload, enter RUN.
REQ-013 busy  output  1  high while not in RUN; processor accesses are ignored.

Function
REQ-014 FSM states: LOAD (preload in progress) and RUN (serving processor); no other states.
REQ-015 LOAD: load_ready = 1, busy = 1; RUN: load_ready = 0, busy = 0.
REQ-016 Preload order: word 0 first, low byte before high byte, 2 bytes per word, 64 bytes in total at default width.
REQ-017 Byte handshake: a byte transfers on a rising edge with load_valid = 1 and load_ready = 1; load_valid low stalls the load without loss.
REQ-018 Low byte is held in an internal byte register; on the high-byte transfer the word {high, low} is written to mem[load_addr].
REQ-019 After each word write, load_addr increments; the write to address 2**ADDR_W-1 wraps load_addr to 0 and moves the FSM to RUN on the same edge.
REQ-020 skip_load = 1 in LOAD moves the FSM to RUN on the next edge.
REQ-021 With skip_load, any half-received word is discarded and never written; already-written words persist.
REQ-022 If skip_load and a completing high byte coincide, that word is written and the FSM still enters RUN.
REQ-023 RUN write: readwriteN = 1 writes data_in to mem[address] at the rising edge.
REQ-024 RUN read: readwriteN = 0 loads mem[address] into data_out at the rising edge (1-cycle latency).
REQ-025 RUN write cycle: data_out is loaded with data_in (write-first), so data_out always reflects mem[address] of the previous cycle.
REQ-026 In LOAD, processor writes have no effect and data_out holds 0.
REQ-027 skip_load and load_valid are ignored in RUN; RUN is exited only by rst.
REQ-028 Memory array has no reset; its contents are undefined until written.

Reset
REQ-029 rst asserted: FSM = LOAD, load_addr = 0, byte phase = low, byte register = 0, data_out = 0, load_ready = 1, busy = 1; takes effect immediately, without waiting for a clock edge.
REQ-030 rst mid-load: the preload restarts at word 0 low byte; memory contents are retained (not cleared).
REQ-031 rst in RUN: the block returns to LOAD; memory contents are retained.

Structure
REQ-032 Shared package holds ADDR_W/DATA_W defaults and the FSM state encoding (LOAD = 0, RUN = 1).
REQ-033 One sub-module, mem_array: storage with one synchronous write port and one registered read port with write-first behaviour.
REQ-034 The FSM, load_addr counter, byte phase and byte register live in memory_unit.

Verification
REQ-035 Reset, then 64 bytes with byte k = k, no stalls -> load_ready drops after byte 63 edge; mem[0] = 0x0100, mem[31] = 0x3F3E; busy = 0.
REQ-036 Preload with load_valid low for 3 cycles between every byte -> identical contents to REQ-035; no duplicate or lost bytes.
REQ-037 After byte 20 (word 10 low byte), assert skip_load -> RUN next edge; mem[9] = 0x1312 written; mem[10] unchanged.
REQ-038 RUN: write 0xBEEF to addr 5, then read addr 5 -> data_out = 0xBEEF on the write edge (write-first) and again on the read edge.
REQ-039 RUN: read addr 3 then addr 4 back-to-back -> data_out = mem[3], then mem[4] on consecutive edges.
REQ-040 Assert rst asynchronously mid-load after byte 40 (between clock edges) -> busy = 1 and data_out = 0 before the next edge; then reload bytes 0xAA, 0x55 -> mem[0] = 0x55AA; mem[20] still holds its pre-reset value.
